// File: rtl/lz_normalise_seq.sv
// lz_normalise_seq: sequential leading-zero normaliser.
// Scans the captured word MSB-first, CHUNK bits per cycle, with one small LZ unit.
// It then left-shifts the word by the accumulated count and returns the result over valid/ready.
// Optional feature macro: LZN_EARLY_EXIT_EN. When defined, the scan stops at the first nonzero
// chunk. Results are the same either way; only the latency changes.
// WIDTH must be a multiple of CHUNK.
module lz_normalise_seq #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned CHUNK = 4,
  localparam int unsigned CW   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_count,
  output logic             out_zero
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned ZW = $clog2(CHUNK + 1);

  typedef enum logic [1:0] {StIdle, StScan, StShift, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [KW-1:0]      k_q, k_d;
  logic               found_q, found_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [CW-1:0]      out_count_q, out_count_d;
  logic               out_zero_q, out_zero_d;

  logic [31:0]        shamt;
  logic [WIDTH-1:0]   aligned;
  logic [CHUNK-1:0]   chunk;
  logic [ZW-1:0]      chunk_lz;
  logic               chunk_hit;
  logic               last_chunk;
  logic               chunk_nonzero;

  // Ready is gated by reset so nothing is taken while reset is held.
  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = (state_q == StDone);
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_zero  = out_zero_q;

  // Select chunk k (MSB-first) by shifting it to the top, then count its leading zeros.
  always_comb begin
    shamt     = 32'(k_q) * CHUNK;
    aligned   = data_q << shamt;
    chunk     = aligned[WIDTH-1 -: CHUNK];
    chunk_lz  = ZW'(CHUNK);
    chunk_hit = 1'b0;
    for (int i = int'(CHUNK) - 1; i >= 0; i--) begin
      if (!chunk_hit && chunk[i]) begin
        chunk_lz  = ZW'(int'(CHUNK) - 1 - i);
        chunk_hit = 1'b1;
      end
    end
    chunk_nonzero = chunk_hit;
    last_chunk    = (k_q == KW'(N - 1));
  end

  // Next-state and datapath updates for the IDLE/SCAN/SHIFT/DONE sequence.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    found_d     = found_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_zero_d  = out_zero_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          data_d  = in_data;
          cnt_d   = '0;
          k_d     = '0;
          found_d = 1'b0;
          state_d = StScan;
        end
      end
      StScan: begin
        k_d = k_q + KW'(1);
        // Once a set bit has been seen the count is final.
        if (!found_q) begin
          cnt_d = cnt_q + CW'(chunk_lz);
          if (chunk_nonzero) begin
            found_d = 1'b1;
          end
        end
`ifdef LZN_EARLY_EXIT_EN
        if (last_chunk || (!found_q && chunk_nonzero)) begin
          state_d = StShift;
        end
`else
        if (last_chunk) begin
          state_d = StShift;
        end
`endif
      end
      StShift: begin
        // A shift by WIDTH (all-zero word) yields zero.
        out_data_d  = data_q << cnt_q;
        out_count_d = cnt_q;
        out_zero_d  = (cnt_q == CW'(WIDTH));
        state_d     = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any word in flight and clears the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      data_q      <= '0;
      cnt_q       <= '0;
      k_q         <= '0;
      found_q     <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      found_q     <= found_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_zero_q  <= out_zero_d;
    end
  end

endmodule

// File: tb/tb_lz_normalise_seq.sv
// Testbench for lz_normalise_seq at WIDTH=24, CHUNK=4.
// Build with or without LZN_EARLY_EXIT_EN; latency expectations follow the macro.
module tb_lz_normalise_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic [4:0]  out_count;
  logic        out_zero;

  int n_checks;
  int n_errors;

  lz_normalise_seq #(
    .WIDTH(24),
    .CHUNK(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] din;
    int          cnt;
    logic [23:0] dout;
    logic        zero;
    int          lat_fixed;
    int          lat_early;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Independent reference: bitwise leading-zero count.
  function automatic int model_lz(input logic [23:0] x);
    for (int i = 23; i >= 0; i--) begin
      if (x[i]) return 23 - i;
    end
    return 24;
  endfunction

  function automatic int model_lat(input int c);
`ifdef LZN_EARLY_EXIT_EN
    int k;
    k = (c >= 24) ? 5 : c / 4;
    return k + 2;
`else
    return 7 + 0 * c;
`endif
  endfunction

  // Count edges after the accept edge until out_valid is seen, bounded.
  task automatic wait_valid(input logic rdy_during, output int edges, output bit got);
    edges = 0;
    got   = 1'b0;
    while (!got && edges < 40) begin
      out_ready = rdy_during;
      @(posedge clk);
      #1;
      edges++;
      if (out_valid) got = 1'b1;
    end
  endtask

  // Caller is always at #1 after a rising edge.
  task automatic run_word(input logic [23:0] x, input int e_cnt, input logic [23:0] e_data,
                          input logic e_zero, input int e_lat, input int idle_gap,
                          input int rdy_gap, input logic early_rdy, input string name);
    int edges;
    bit got;
    repeat (idle_gap) begin
      @(posedge clk);
      #1;
    end
    chk({name, " in_ready idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = x;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 24'(~x);
    wait_valid(early_rdy, edges, got);
    if (!got) begin
      chk({name, " timeout"}, 32'(got), 32'd1);
      out_ready = 1'b0;
      return;
    end
    chk({name, " latency"}, 32'(edges), 32'(e_lat));
    chk({name, " count"}, 32'(out_count), 32'(e_cnt));
    chk({name, " data"}, 32'(out_data), 32'(e_data));
    chk({name, " zero"}, 32'(out_zero), 32'(e_zero));
    if (!early_rdy) begin
      out_ready = 1'b0;
      repeat (rdy_gap) begin
        @(posedge clk);
        #1;
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({name, " released"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    int          edges;
    bit          got;
    bit          stable;
    bit          stray;
    logic [23:0] x;
    int          c;
    int          m;

    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    vecs[0] = '{24'h000123, 15, 24'h918000, 1'b0, 7, 5};
    vecs[1] = '{24'h000000, 24, 24'h000000, 1'b1, 7, 7};
    vecs[2] = '{24'h800000, 0,  24'h800000, 1'b0, 7, 2};
    vecs[3] = '{24'h000001, 23, 24'h800000, 1'b0, 7, 7};
    vecs[4] = '{24'h00F000, 8,  24'hF00000, 1'b0, 7, 4};
    vecs[5] = '{24'h400000, 1,  24'h800000, 1'b0, 7, 2};
    vecs[6] = '{24'h0A5A5A, 4,  24'hA5A5A0, 1'b0, 7, 3};
    vecs[7] = '{24'h012345, 7,  24'h91A280, 1'b0, 7, 3};
    vecs[8] = '{24'hFFFFFF, 0,  24'hFFFFFF, 1'b0, 7, 2};
    vecs[9] = '{24'h000080, 16, 24'h800000, 1'b0, 7, 6};

    #1;
    chk("reset in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset outputs", {out_valid, out_zero, out_count, out_data}, 32'd0);
    chk("reset in_ready release", 32'(in_ready), 32'd1);

    // Directed table.
    for (int i = 0; i < 10; i++) begin
`ifdef LZN_EARLY_EXIT_EN
      run_word(vecs[i].din, vecs[i].cnt, vecs[i].dout, vecs[i].zero, vecs[i].lat_early,
               i % 3, i % 4, 1'(i % 2), $sformatf("vec%0d", i));
`else
      run_word(vecs[i].din, vecs[i].cnt, vecs[i].dout, vecs[i].zero, vecs[i].lat_fixed,
               i % 3, i % 4, 1'(i % 2), $sformatf("vec%0d", i));
`endif
    end

    // Reset two cycles into SCAN; outputs still hold the previous nonzero result.
    in_valid = 1'b1;
    in_data  = 24'h000123;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midreset out_valid", 32'(out_valid), 32'd0);
    chk("midreset out_data", 32'(out_data), 32'd0);
    chk("midreset count_zero", {26'd0, out_zero, out_count}, 32'd0);
    chk("midreset in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("postreset in_ready", 32'(in_ready), 32'd1);
    stray = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_valid) stray = 1'b1;
    end
    chk("postreset no result", 32'(stray), 32'd0);

    // Backpressure: hold the result while a second word waits.
    in_valid = 1'b1;
    in_data  = 24'h000123;
    @(posedge clk);
    #1;
    in_data = 24'h800000;
    wait_valid(1'b0, edges, got);
    chk("bp first valid", 32'(got), 32'd1);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (!(out_valid && !in_ready && out_data == 24'h918000 && out_count == 5'd15 &&
            !out_zero)) stable = 1'b0;
    end
    chk("bp held stable", 32'(stable), 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp idle after release", {30'd0, out_valid, in_ready}, 32'b01);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp second accepted", 32'(in_ready), 32'd0);
    wait_valid(1'b0, edges, got);
    chk("bp second valid", 32'(got), 32'd1);
`ifdef LZN_EARLY_EXIT_EN
    chk("bp second latency", 32'(edges), 32'd2);
`else
    chk("bp second latency", 32'(edges), 32'd7);
`endif
    chk("bp second result", {out_zero, out_count, out_data}, {1'b0, 5'd0, 24'h800000});
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Random words against the bitwise model, with stalls on both sides.
    for (int n = 0; n < 1000; n++) begin
      x = 24'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        m = $urandom_range(1, 6);
        x = x >> (4 * m);
      end
      c = model_lz(x);
      run_word(x, c, x << c, 1'(c == 24), model_lat(c), $urandom_range(0, 2),
               $urandom_range(0, 3), 1'($urandom_range(0, 1)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
